// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling
module uart_rx #(
  parameter int BAUD_DIV = 5208,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] SAMPLE_CNT = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] LAST_CNT   = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic            rx_s1, rx_s2, rx_s3;
  logic [CW-1:0]   baud_cnt;
  logic [3:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            fall_edge, sample_pt, baud_wrap;
  logic            shift_en, done_set, err_set;

  assign fall_edge = rx_s3 & ~rx_s2;
  assign sample_pt = (baud_cnt == SAMPLE_CNT);
  assign baud_wrap = (baud_cnt == LAST_CNT);
  assign rx_busy   = (state != IDLE);

  // Flops preset to 1 so reset release on an idle line never looks like a start edge
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rs232_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE:  if (fall_edge) state_next = START;
      START: if (sample_pt) state_next = rx_s2 ? IDLE : DATA;
      DATA: begin
        if (sample_pt && !bit_cnt[3]) shift_en = 1'b1;
        if (baud_wrap && bit_cnt == 4'd8) state_next = STOP;
      end
      STOP: begin
        if (sample_pt) begin
          done_set   = rx_s2;
          err_set    = ~rx_s2;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters idle at zero, so entering START from IDLE starts a clean bit period
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      baud_cnt  <= '0;
      bit_cnt   <= 4'd0;
      shift_reg <= 8'h00;
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= done_set;
      frame_err <= err_set;
      if (state == IDLE) begin
        baud_cnt <= '0;
        bit_cnt  <= 4'd0;
      end else begin
        baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
      end
      if (shift_en) begin
        shift_reg[bit_cnt[2:0]] <= rx_s2;
        bit_cnt                 <= bit_cnt + 4'd1;
      end
      if (done_set) rx_data <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at BAUD_DIV=16, HALF_DIV=8
module tb_uart_rx;

  localparam int BD = 16;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       s_rst = 1'b1;
  logic       rs232_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, frame_err, rx_busy;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   done_cyc[$];
  exp_t mon_e;

  uart_rx #(.BAUD_DIV(BD), .HALF_DIV(BD / 2)) dut (
    .sclk(clk), .s_rst(s_rst), .rs232_rx(rs232_rx),
    .rx_data(rx_data), .rx_done(rx_done), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  // Every output pulse must match the oldest expected frame outcome
  always @(negedge clk) begin
    if (rx_done || frame_err) begin
      n_cmp++;
      if (rx_done && frame_err) begin
        n_fail++;
        $display("FAIL both_pulses rx_done=%0b frame_err=%0b required at most one", rx_done, frame_err);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse rx_done=%0b frame_err=%0b required none", rx_done, frame_err);
      end else begin
        mon_e = exp_q.pop_front();
        if (frame_err !== mon_e.err || rx_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL pulse_check err=%0b data=%02h required err=%0b data=%02h",
                   frame_err, rx_data, mon_e.err, mon_e.data);
        end
        if (rx_done) done_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int per);
    rs232_rx = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = d[i];
      repeat (per) @(negedge clk);
    end
    rs232_rx = stop_bit;
    repeat (per) @(negedge clk);
    rs232_rx = 1'b1;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    s_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%02h exp=00", rx_data); end
    n_cmp++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_rx_done got=%0b exp=0", rx_done); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%0b exp=0", frame_err); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy got=%0b exp=0", rx_busy); end
    s_rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_frame_55;
    int t0, lat;
    t0 = cyc;
    exp_q.push_back('{err: 1'b0, data: 8'h55});
    send_frame(8'h55, 1'b1, BD);
    wait_drain(200);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL f55_pending got=%0d exp=0", exp_q.size()); end
    lat = (done_cyc.size() != 0) ? done_cyc[$] - t0 : -1;
    n_cmp++; if (lat < 154 || lat > 156) begin n_fail++; $display("FAIL f55_latency got=%0d exp=155+-1", lat); end
    repeat (4) @(negedge clk);
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL f55_busy got=%0b exp=0", rx_busy); end
    n_cmp++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL f55_data got=%02h exp=55", rx_data); end
  endtask

  task automatic test_glitch;
    rs232_rx = 1'b0;
    repeat (3) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start got=%0b exp=1", rx_busy); end
    repeat (30) @(negedge clk);
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end got=%0b exp=0", rx_busy); end
    n_cmp++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL glitch_data got=%02h exp=55", rx_data); end
  endtask

  task automatic test_frame_err;
    exp_q.push_back('{err: 1'b1, data: 8'h55});
    send_frame(8'hA5, 1'b0, BD);
    wait_drain(200);
    repeat (20) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ferr_pending got=%0d exp=0", exp_q.size()); end
    n_cmp++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL ferr_data got=%02h exp=55", rx_data); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy got=%0b exp=0", rx_busy); end
  endtask

  task automatic test_back_to_back;
    int n0, gap;
    n0 = done_cyc.size();
    exp_q.push_back('{err: 1'b0, data: 8'h7F});
    exp_q.push_back('{err: 1'b0, data: 8'h00});
    send_frame(8'h7F, 1'b1, BD);
    send_frame(8'h00, 1'b1, BD);
    wait_drain(200);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_pending got=%0d exp=0", exp_q.size()); end
    gap = (done_cyc.size() == n0 + 2) ? done_cyc[n0 + 1] - done_cyc[n0] : -1;
    n_cmp++; if (gap < 159 || gap > 161) begin n_fail++; $display("FAIL b2b_gap got=%0d exp=160+-1", gap); end
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL b2b_data got=%02h exp=00", rx_data); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    d = 8'h3C;
    rs232_rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rs232_rx = d[i];
      repeat (BD) @(negedge clk);
    end
    rs232_rx = d[4];
    repeat (5) @(negedge clk);
    s_rst = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    rs232_rx = 1'b1;
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%0b exp=0", rx_busy); end
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got=%02h exp=00", rx_data); end
    repeat (200) @(negedge clk);
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got=%0b exp=0", rx_busy); end
    exp_q.push_back('{err: 1'b0, data: 8'hC3});
    send_frame(8'hC3, 1'b1, BD);
    wait_drain(200);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL c3_pending got=%0d exp=0", exp_q.size()); end
    n_cmp++; if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL c3_data got=%02h exp=c3", rx_data); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_baud_skew;
    exp_q.push_back('{err: 1'b0, data: 8'h96});
    send_frame(8'h96, 1'b1, BD + 1);
    wait_drain(200);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL skew_pending got=%0d exp=0", exp_q.size()); end
    n_cmp++; if (rx_data !== 8'h96) begin n_fail++; $display("FAIL skew_data got=%02h exp=96", rx_data); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_break;
    exp_q.push_back('{err: 1'b1, data: 8'h96});
    rs232_rx = 1'b0;
    repeat (500) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL break_pending got=%0d exp=0", exp_q.size()); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL break_busy got=%0b exp=0", rx_busy); end
    rs232_rx = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL break_release got=%0b exp=0", rx_busy); end
    n_cmp++; if (rx_data !== 8'h96) begin n_fail++; $display("FAIL break_data got=%02h exp=96", rx_data); end
  endtask

  initial begin
    test_reset();
    test_frame_55();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_baud_skew();
    test_break();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
